// File: rtl/matrix_result_streamer.sv
// Streams an M x N row-major matrix out of a synchronous BRAM as a valid/ready
// element stream, tagging the end of each row and the final element.
module matrix_result_streamer #(
    parameter int ELEMENT_WIDTH = 8,
    parameter int ADDR_WIDTH    = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [4:0]               dim_m,
    input  logic [4:0]               dim_n,
    input  logic [ADDR_WIDTH-1:0]    addr_base,
    output logic                     mem_rd_en,
    output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
    input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ELEMENT_WIDTH-1:0] out_data,
    output logic                     out_row_end,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        SEND    = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                   state_r;
    state_t                   next_state_s;
    logic                     start_d_r;
    logic                     launch_s;
    logic                     dims_ok_s;
    logic                     accept_s;
    logic [4:0]               dim_m_r;
    logic [4:0]               dim_n_r;
    logic [4:0]               row_r;
    logic [4:0]               col_r;
    logic [ADDR_WIDTH-1:0]    elem_addr_r;
    logic                     mem_rd_en_r;
    logic [ADDR_WIDTH-1:0]    mem_rd_addr_r;
    logic                     out_valid_r;
    logic [ELEMENT_WIDTH-1:0] out_data_r;
    logic                     out_row_end_r;
    logic                     out_last_r;
    logic                     busy_r;
    logic                     done_r;
    logic                     err_r;

    assign launch_s  = (state_r == IDLE) && start && !start_d_r;
    assign dims_ok_s = (dim_m != 5'd0) && (dim_m <= 5'd16) &&
                       (dim_n != 5'd0) && (dim_n <= 5'd16);
    assign accept_s  = (state_r == SEND) && out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (launch_s) begin
                    if (dims_ok_s) begin
                        next_state_s = READ;
                    end else begin
                        next_state_s = DONE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            READ:    next_state_s = WAIT;
            WAIT:    next_state_s = CAPTURE;
            CAPTURE: next_state_s = SEND;
            SEND: begin
                if (out_ready) begin
                    if (out_last_r) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = READ;
                    end
                end else begin
                    next_state_s = SEND;
                end
            end
            DONE: begin
                if (!start) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Datapath, counters and registered outputs. Rows are contiguous, so the
    // read address is a running pointer equal to base + row*dim_n + col.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_d_r     <= 1'b0;
            dim_m_r       <= 5'd0;
            dim_n_r       <= 5'd0;
            row_r         <= 5'd0;
            col_r         <= 5'd0;
            elem_addr_r   <= '0;
            mem_rd_en_r   <= 1'b0;
            mem_rd_addr_r <= '0;
            out_valid_r   <= 1'b0;
            out_data_r    <= '0;
            out_row_end_r <= 1'b0;
            out_last_r    <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            start_d_r   <= start;
            mem_rd_en_r <= (state_r == READ);
            case (state_r)
                IDLE: begin
                    if (launch_s) begin
                        dim_m_r     <= dim_m;
                        dim_n_r     <= dim_n;
                        elem_addr_r <= addr_base;
                        row_r       <= 5'd0;
                        col_r       <= 5'd0;
                        err_r       <= !dims_ok_s;
                        busy_r      <= dims_ok_s;
                        done_r      <= !dims_ok_s;
                    end
                end
                READ: begin
                    mem_rd_addr_r <= elem_addr_r;
                end
                CAPTURE: begin
                    out_data_r    <= mem_rd_data;
                    out_row_end_r <= (col_r == dim_n_r - 5'd1);
                    out_last_r    <= (row_r == dim_m_r - 5'd1) && (col_r == dim_n_r - 5'd1);
                    out_valid_r   <= 1'b1;
                end
                SEND: begin
                    if (accept_s) begin
                        out_valid_r <= 1'b0;
                        elem_addr_r <= elem_addr_r + ADDR_WIDTH'(1);
                        if (col_r == dim_n_r - 5'd1) begin
                            col_r <= 5'd0;
                            row_r <= row_r + 5'd1;
                        end else begin
                            col_r <= col_r + 5'd1;
                        end
                        if (out_last_r) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        done_r <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_rd_en   = mem_rd_en_r;
    assign mem_rd_addr = mem_rd_addr_r;
    assign out_valid   = out_valid_r;
    assign out_data    = out_data_r;
    assign out_row_end = out_row_end_r;
    assign out_last    = out_last_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed bench for matrix_result_streamer with a synchronous BRAM model
// and a negedge monitor that records reads and accepted elements.
module tb_matrix_result_streamer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] dim_m;
    logic [4:0] dim_n;
    logic [9:0] addr_base;
    logic       mem_rd_en;
    logic [9:0] mem_rd_addr;
    logic [7:0] mem_rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_row_end;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       err;

    int checks;
    int errors;

    logic [7:0] mem [0:1023];
    logic [7:0] data_q[$];
    bit         rowend_q[$];
    bit         last_q[$];
    logic [9:0] addr_q[$];
    int         valid_cycles;

    matrix_result_streamer #(.ELEMENT_WIDTH(8), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dim_m(dim_m), .dim_n(dim_n),
        .addr_base(addr_base), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row_end(out_row_end), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    // Inputs change just after posedge, so negedge sees what the next edge will use.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) addr_q.push_back(mem_rd_addr);
            if (out_valid) valid_cycles++;
            if (out_valid && out_ready) begin
                data_q.push_back(out_data);
                rowend_q.push_back(out_row_end);
                last_q.push_back(out_last);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        data_q.delete();
        rowend_q.delete();
        last_q.delete();
        addr_q.delete();
        valid_cycles = 0;
    endtask

    task automatic launch(input logic [4:0] m, input logic [4:0] n, input logic [9:0] base);
        dim_m     = m;
        dim_n     = n;
        addr_base = base;
        start     = 1'b1;
        step();
    endtask

    task automatic wait_done(input int budget, input string name, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            step();
            cycles++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: done=%0b after %0d cycles, required 1", name, done, cycles);
        end
    endtask

    task automatic release_start();
        start = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        checks++;
        if ({mem_rd_en, mem_rd_addr, out_valid, out_data, out_row_end, out_last, busy, done, err} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rd_en=%0b addr=%h valid=%0b data=%h re=%0b last=%0b busy=%0b done=%0b err=%0b, required all 0",
                     mem_rd_en, mem_rd_addr, out_valid, out_data, out_row_end, out_last, busy, done, err);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%0b done=%0b, required 0 0", busy, done);
        end
    endtask

    task automatic test_2x3();
        int cyc;
        for (int i = 0; i < 6; i++) mem[10'h040 + i] = 8'(i + 1);
        out_ready = 1'b1;
        clear_mon();
        launch(5'd2, 5'd3, 10'h040);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL 2x3_busy: busy=%0b, required 1", busy);
        end
        wait_done(100, "2x3", cyc);
        checks++;
        if (cyc != 24) begin
            errors++;
            $display("FAIL 2x3_latency: done after %0d cycles, required 24", cyc);
        end
        checks++;
        if (data_q.size() != 6 || addr_q.size() != 6) begin
            errors++;
            $display("FAIL 2x3_count: %0d elements %0d reads, required 6 6", data_q.size(), addr_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (data_q[i] !== 8'(i + 1) || rowend_q[i] !== (i == 2 || i == 5) ||
                    last_q[i] !== (i == 5) || addr_q[i] !== 10'(10'h040 + i)) begin
                    errors++;
                    $display("FAIL 2x3_elem%0d: data=%h re=%0b last=%0b addr=%h, required %h %0b %0b %h",
                             i, data_q[i], rowend_q[i], last_q[i], addr_q[i], 8'(i + 1),
                             (i == 2 || i == 5), (i == 5), 10'(10'h040 + i));
                end
            end
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL 2x3_done_flags: busy=%0b err=%0b, required 0 0", busy, err);
        end
        release_start();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL 2x3_done_clear: done=%0b, required 0", done);
        end
    endtask

    task automatic test_1x1();
        int cyc;
        mem[10'h3FF] = 8'hA5;
        clear_mon();
        launch(5'd1, 5'd1, 10'h3FF);
        wait_done(20, "1x1", cyc);
        checks++;
        if (addr_q.size() != 1 || data_q.size() != 1) begin
            errors++;
            $display("FAIL 1x1_count: %0d reads %0d elements, required 1 1", addr_q.size(), data_q.size());
        end else begin
            checks++;
            if (addr_q[0] !== 10'h3FF || data_q[0] !== 8'hA5 || rowend_q[0] !== 1'b1 || last_q[0] !== 1'b1) begin
                errors++;
                $display("FAIL 1x1_elem: addr=%h data=%h re=%0b last=%0b, required 3ff a5 1 1",
                         addr_q[0], data_q[0], rowend_q[0], last_q[0]);
            end
        end
        release_start();
    endtask

    task automatic test_backpressure();
        int cyc;
        int guard;
        int reads;
        for (int i = 0; i < 9; i++) mem[10'h100 + i] = 8'(8'h10 + i);
        out_ready = 1'b1;
        clear_mon();
        launch(5'd3, 5'd3, 10'h100);
        guard = 0;
        while (!(out_valid && data_q.size() == 3) && guard < 100) begin
            step();
            guard++;
        end
        out_ready = 1'b0;
        reads = addr_q.size();
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h13) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%0b data=%h, required 1 13", k, out_valid, out_data);
            end
        end
        checks++;
        if (addr_q.size() != reads || reads != 4) begin
            errors++;
            $display("FAIL bp_no_extra_read: reads=%0d then %0d, required 4", reads, addr_q.size());
        end
        out_ready = 1'b1;
        wait_done(100, "bp", cyc);
        checks++;
        if (data_q.size() != 9 || addr_q.size() != 9) begin
            errors++;
            $display("FAIL bp_count: %0d elements %0d reads, required 9 9", data_q.size(), addr_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (data_q[i] !== 8'(8'h10 + i)) begin
                    errors++;
                    $display("FAIL bp_order%0d: data=%h, required %h", i, data_q[i], 8'(8'h10 + i));
                end
            end
        end
        release_start();
    endtask

    task automatic test_illegal();
        int cyc;
        clear_mon();
        launch(5'd0, 5'd3, 10'h000);
        wait_done(10, "ill_m0", cyc);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || addr_q.size() != 0 || valid_cycles != 0) begin
            errors++;
            $display("FAIL ill_m0: err=%0b busy=%0b reads=%0d valid=%0d, required 1 0 0 0",
                     err, busy, addr_q.size(), valid_cycles);
        end
        release_start();
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL ill_err_hold: err=%0b, required 1", err);
        end
        clear_mon();
        launch(5'd2, 5'd17, 10'h000);
        wait_done(10, "ill_n17", cyc);
        checks++;
        if (err !== 1'b1 || addr_q.size() != 0 || valid_cycles != 0) begin
            errors++;
            $display("FAIL ill_n17: err=%0b reads=%0d valid=%0d, required 1 0 0", err, addr_q.size(), valid_cycles);
        end
        release_start();
        launch(5'd1, 5'd2, 10'h000);
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ill_recover: err=%0b busy=%0b, required 0 1", err, busy);
        end
        wait_done(40, "ill_recover", cyc);
        release_start();
    endtask

    task automatic test_16x16();
        int cyc;
        int bad;
        int lasts;
        int reads;
        for (int i = 0; i < 256; i++) mem[10'h200 + i] = 8'(i);
        out_ready = 1'b1;
        clear_mon();
        launch(5'd16, 5'd16, 10'h200);
        dim_m = 5'd3;
        dim_n = 5'd0;
        addr_base = 10'h000;
        wait_done(1200, "16x16", cyc);
        checks++;
        if (data_q.size() != 256 || addr_q.size() != 256) begin
            errors++;
            $display("FAIL 16x16_count: %0d elements %0d reads, required 256 256", data_q.size(), addr_q.size());
        end else begin
            bad = 0;
            lasts = 0;
            for (int i = 0; i < 256; i++) begin
                if (data_q[i] !== 8'(i) || rowend_q[i] !== ((i % 16) == 15)) bad++;
                if (last_q[i]) lasts++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL 16x16_data: %0d bad elements, required 0", bad);
            end
            checks++;
            if (addr_q[255] !== 10'h2FF || lasts != 1 || last_q[255] !== 1'b1) begin
                errors++;
                $display("FAIL 16x16_last: addr=%h lasts=%0d final_last=%0b, required 2ff 1 1",
                         addr_q[255], lasts, last_q[255]);
            end
        end
        reads = addr_q.size();
        for (int k = 0; k < 10; k++) step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || addr_q.size() != reads) begin
            errors++;
            $display("FAIL 16x16_no_relaunch: done=%0b busy=%0b reads=%0d, required 1 0 %0d",
                     done, busy, addr_q.size(), reads);
        end
        release_start();
    endtask

    task automatic test_reset_mid();
        int cyc;
        int guard;
        for (int i = 0; i < 9; i++) mem[10'h000 + i] = 8'(8'h30 + i);
        out_ready = 1'b1;
        clear_mon();
        launch(5'd3, 5'd3, 10'h000);
        guard = 0;
        while (!(out_valid && data_q.size() == 4) && guard < 100) begin
            step();
            guard++;
        end
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if ({mem_rd_en, mem_rd_addr, out_valid, out_data, out_row_end, out_last, busy, done, err} !== 25'd0) begin
            errors++;
            $display("FAIL midreset_outputs: rd_en=%0b addr=%h valid=%0b data=%h re=%0b last=%0b busy=%0b done=%0b err=%0b, required all 0",
                     mem_rd_en, mem_rd_addr, out_valid, out_data, out_row_end, out_last, busy, done, err);
        end
        step();
        rst_n = 1'b1;
        step();
        clear_mon();
        launch(5'd3, 5'd3, 10'h000);
        wait_done(100, "midreset", cyc);
        checks++;
        if (data_q.size() != 9 || addr_q.size() != 9) begin
            errors++;
            $display("FAIL midreset_count: %0d elements %0d reads, required 9 9", data_q.size(), addr_q.size());
        end else begin
            checks++;
            if (addr_q[0] !== 10'h000 || data_q[0] !== 8'h30 || data_q[8] !== 8'h38) begin
                errors++;
                $display("FAIL midreset_restart: addr0=%h data0=%h data8=%h, required 000 30 38",
                         addr_q[0], data_q[0], data_q[8]);
            end
        end
        release_start();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        start       = 1'b0;
        out_ready   = 1'b1;
        dim_m       = 5'd1;
        dim_n       = 5'd1;
        addr_base   = 10'h000;
        mem_rd_data = 8'h00;
        rst_n       = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        clear_mon();
        #2;
        test_reset();
        test_2x3();
        test_1x1();
        test_backpressure();
        test_illegal();
        test_16x16();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_result_streamer.md
MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

Interface
REQ-001 SHALL have parameter ELEMENT_WIDTH, default 8, bit width of one matrix element.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, BRAM address width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  level request; a rising edge seen in IDLE launches one stream.
REQ-006 SHALL have port dim_m  input  5  rows of the result matrix, legal 1..16.
REQ-007 SHALL have port dim_n  input  5  columns of the result matrix, legal 1..16.
REQ-008 SHALL have port addr_base  input  ADDR_WIDTH  address of element (0,0), row-major.
REQ-009 SHALL have port mem_rd_en  output  1  BRAM read strobe.
REQ-010 SHALL have port mem_rd_addr  output  ADDR_WIDTH  BRAM read address.
REQ-011 SHALL have port mem_rd_data  input  ELEMENT_WIDTH  BRAM read data.
REQ-012 SHALL have port out_valid  output  1  out_data holds a valid element.
REQ-013 SHALL have port out_ready  input  1  consumer accepts the element when high with out_valid.
REQ-014 SHALL have port out_data  output  ELEMENT_WIDTH  element value.
REQ-015 SHALL have port out_row_end  output  1  current element is the last of its row.
REQ-016 SHALL have port out_last  output  1  current element is the last of the matrix.
REQ-017 SHALL have port busy  output  1  high from launch until DONE is entered.
REQ-018 SHALL have port done  output  1  stream complete, held until start is low.
REQ-019 SHALL have port err  output  1  illegal dimensions flagged at launch.

Function
REQ-020 SHALL latch dim_m, dim_n and addr_base at launch; later input changes SHALL NOT affect the stream.
REQ-021 SHALL implement states IDLE, READ, WAIT, CAPTURE, SEND, DONE.
REQ-022 IDLE: in IDLE with start high, SHALL clear row and column counters, clear err, set busy, and go to READ; if either dim is 0 or >16, SHALL instead set err and go to DONE with no read and no output.
REQ-023 READ: SHALL register mem_rd_en=1 and mem_rd_addr=base+row*dim_n+col, truncated to ADDR_WIDTH, then go to WAIT.
REQ-024 WAIT: SHALL drive mem_rd_en=0; BRAM data is valid in the next cycle.
REQ-025 CAPTURE: SHALL register out_data=mem_rd_data, out_row_end=(col==dim_n-1), out_last=(row==dim_m-1 && col==dim_n-1), and out_valid=1, then go to SEND.
REQ-026 SEND: SHALL hold out_valid, out_data, out_row_end and out_last stable while out_ready is low.
REQ-027 SEND: on the cycle with out_ready high, SHALL drop out_valid next cycle and advance col; when col wraps from dim_n-1 to 0, row SHALL advance; after the out_last element it SHALL go to DONE, otherwise to READ.
REQ-028 Per-element latency from READ entry to out_valid SHALL be 3 cycles; with out_ready tied high, each element SHALL cost exactly 4 cycles.
REQ-029 DONE: SHALL drop busy, assert done, and return to IDLE when start is low, clearing done; err SHALL hold its value until the next launch.
REQ-030 Start held high across DONE SHALL NOT relaunch; a new launch SHALL require start low then high.
REQ-031 At most one read SHALL be outstanding; mem_rd_en SHALL be high for exactly one cycle per element.
REQ-032 The 1x1 matrix SHALL emit one element with out_row_end=1 and out_last=1.

Reset
REQ-033 On rst_n low, at any time including mid-stream, the block SHALL immediately enter IDLE.
REQ-034 On rst_n low, outputs SHALL be mem_rd_en=0, mem_rd_addr=0, out_valid=0, out_data=0, out_row_end=0, out_last=0, busy=0, done=0, err=0.
REQ-035 On rst_n low, the counters SHALL clear; an element pending in SEND SHALL be discarded without handshake.

Verification
REQ-036 2x3 at addr_base=0x040, memory 1..6, out_ready=1: outputs 1..6 in order, with out_row_end on 3 and 6, out_last only on 6, done after 24 cycles.
REQ-037 1x1 at addr_base=0x3FF holding 0xA5: one read at 0x3FF, out_data=0xA5 with row_end=last=1.
REQ-038 3x3 with out_ready low for 5 cycles on element 4: out_data is held, no extra read is issued, order is preserved, all 9 elements are delivered exactly once.
REQ-039 dim_m=0 or dim_n=17: err=1 and done=1 with zero mem_rd_en pulses and zero out_valid; a following legal launch clears err.
REQ-040 16x16: 256 elements delivered, the last address is base+255, out_last only on the final element, and start held high after done does not relaunch.
REQ-041 rst_n pulsed low mid-stream on element 5 of a 3x3: all outputs are 0 at once; a fresh launch restarts at element (0,0).
